instr_fetch_ctrl: RTL and testbench

Fetch-stage controller for the MIPS pipeline. It owns the PC and drives the word index into the combinational instruction memory. It registers the fetched instruction into the IF/ID outputs and sequences stalls, branch/jump redirects and fetch faults. It also keeps fetch/stall/flush performance counters.

---
 rtl/fetch_pkg.sv | 18 +
 rtl/instr_fetch_ctrl_perf_counter.sv | 18 +
 rtl/instr_fetch_ctrl.sv | 134 +++++++++++++
 tb/tb_instr_fetch_ctrl.sv | 203 ++++++++++++++++++++
 4 files changed

// File: rtl/fetch_pkg.sv
// Shared types and helpers for the fetch stage: FSM state encoding, default reset PC
// and the PC range check used to detect fetches past the end of instruction memory.
package fetch_pkg;

  typedef enum logic [1:0] {
    BOOT  = 2'b00,
    RUN   = 2'b01,
    FAULT = 2'b10
  } fetch_state_t;

  localparam logic [31:0] RESET_PC_DEFAULT = 32'h0000_0000;

  // Widened to 33 bits so a full-range pc never aliases into range.
  function automatic logic pc_in_range(input logic [31:0] pc, input int unsigned words);
    return ({1'b0, pc} < (33'(words) * 33'd4));
  endfunction

endpackage

// File: rtl/instr_fetch_ctrl_perf_counter.sv
// 32-bit event counter: +1 on each enabled cycle, wraps modulo 2^32; zeroed by sync reset.
// Latency 1 cycle from en to count; no backpressure.
module perf_counter (
  input  logic        clk,
  input  logic        reset,
  input  logic        en,
  output logic [31:0] count
);

  always_ff @(posedge clk) begin
    if (reset) begin
      count <= 32'd0;
    end else if (en) begin
      count <= count + 32'd1;
    end
  end

endmodule

// File: rtl/instr_fetch_ctrl.sv
// Fetch-stage controller: owns the PC, reads async imem, fills IF/ID with 1-cycle latency.
// Backpressure: stall freezes PC and IF/ID; redirect beats stall; a bad PC parks in FAULT until reset.
module instr_fetch_ctrl
  import fetch_pkg::*;
#(
  parameter int unsigned MEM_WORDS = 64,
  parameter int unsigned ADDR_W    = 6,
  parameter logic [31:0] RESET_PC  = RESET_PC_DEFAULT
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              stall,
  input  logic              redirect_valid,
  input  logic [31:0]       redirect_pc,
  output logic [ADDR_W-1:0] imem_addr,
  input  logic [31:0]       imem_instr,
  input  logic              imem_error,
  output logic              if_valid,
  output logic [31:0]       if_instr,
  output logic [31:0]       if_pc,
  output logic [31:0]       if_pc_plus4,
  output logic              fault,
  output logic [31:0]       fault_pc,
  output logic [31:0]       fetch_count,
  output logic [31:0]       stall_count,
  output logic [31:0]       flush_count
);

  fetch_state_t state_q, state_d;
  logic [31:0]  pc_q, pc_d;
  logic         if_valid_d;
  logic [31:0]  if_instr_d, if_pc_d, if_pc_plus4_d;
  logic         fault_d;
  logic [31:0]  fault_pc_d;
  logic         fetch_inc, stall_inc, flush_inc;
  logic         pc_bad;

  assign imem_addr = pc_q[ADDR_W+1:2];
  assign pc_bad    = (pc_q[1:0] != 2'b00) || !pc_in_range(pc_q, MEM_WORDS) || imem_error;

  always_comb begin
    state_d       = state_q;
    pc_d          = pc_q;
    if_valid_d    = if_valid;
    if_instr_d    = if_instr;
    if_pc_d       = if_pc;
    if_pc_plus4_d = if_pc_plus4;
    fault_d       = fault;
    fault_pc_d    = fault_pc;
    fetch_inc     = 1'b0;
    stall_inc     = 1'b0;
    flush_inc     = 1'b0;

    case (state_q)
      BOOT: begin
        state_d    = RUN;
        if_valid_d = 1'b0;
      end
      RUN: begin
        // A redirect target is only validated once it becomes the pc, via pc_bad.
        if (redirect_valid) begin
          pc_d       = redirect_pc;
          if_valid_d = 1'b0;
          flush_inc  = 1'b1;
        end else if (stall) begin
          stall_inc = 1'b1;
        end else if (pc_bad) begin
          state_d    = FAULT;
          fault_d    = 1'b1;
          fault_pc_d = pc_q;
          if_valid_d = 1'b0;
        end else begin
          if_instr_d    = imem_instr;
          if_pc_d       = pc_q;
          if_pc_plus4_d = pc_q + 32'd4;
          if_valid_d    = 1'b1;
          pc_d          = pc_q + 32'd4;
          fetch_inc     = 1'b1;
        end
      end
      FAULT: begin
        if_valid_d = 1'b0;
      end
      default: begin
        state_d    = BOOT;
        if_valid_d = 1'b0;
      end
    endcase
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q     <= BOOT;
      pc_q        <= RESET_PC;
      if_valid    <= 1'b0;
      if_instr    <= 32'd0;
      if_pc       <= 32'd0;
      if_pc_plus4 <= 32'd0;
      fault       <= 1'b0;
      fault_pc    <= 32'd0;
    end else begin
      state_q     <= state_d;
      pc_q        <= pc_d;
      if_valid    <= if_valid_d;
      if_instr    <= if_instr_d;
      if_pc       <= if_pc_d;
      if_pc_plus4 <= if_pc_plus4_d;
      fault       <= fault_d;
      fault_pc    <= fault_pc_d;
    end
  end

  perf_counter u_fetch_cnt (
    .clk   (clk),
    .reset (reset),
    .en    (fetch_inc),
    .count (fetch_count)
  );

  perf_counter u_stall_cnt (
    .clk   (clk),
    .reset (reset),
    .en    (stall_inc),
    .count (stall_count)
  );

  perf_counter u_flush_cnt (
    .clk   (clk),
    .reset (reset),
    .en    (flush_inc),
    .count (flush_count)
  );

endmodule

// File: tb/tb_instr_fetch_ctrl.sv
// Bench for instr_fetch_ctrl: directed walk through fetch/stall/redirect/fault scenarios,
// then randomized traffic, every cycle compared against a cycle-level behavioural model.
module tb_instr_fetch_ctrl;

  localparam int MEM_WORDS = 64;
  localparam int ADDR_W    = 6;

  logic              clk = 1'b0;
  logic              reset = 1'b1;
  logic              stall = 1'b0;
  logic              redirect_valid = 1'b0;
  logic [31:0]       redirect_pc = 32'd0;
  logic [ADDR_W-1:0] imem_addr;
  logic [31:0]       imem_instr;
  logic              imem_error = 1'b0;
  logic              if_valid;
  logic [31:0]       if_instr, if_pc, if_pc_plus4;
  logic              fault;
  logic [31:0]       fault_pc, fetch_count, stall_count, flush_count;

  logic [31:0] mem [MEM_WORDS];
  assign imem_instr = mem[imem_addr];

  always #5 clk = ~clk;

  instr_fetch_ctrl #(.MEM_WORDS(MEM_WORDS), .ADDR_W(ADDR_W), .RESET_PC(32'h0)) dut (
    .clk            (clk),
    .reset          (reset),
    .stall          (stall),
    .redirect_valid (redirect_valid),
    .redirect_pc    (redirect_pc),
    .imem_addr      (imem_addr),
    .imem_instr     (imem_instr),
    .imem_error     (imem_error),
    .if_valid       (if_valid),
    .if_instr       (if_instr),
    .if_pc          (if_pc),
    .if_pc_plus4    (if_pc_plus4),
    .fault          (fault),
    .fault_pc       (fault_pc),
    .fetch_count    (fetch_count),
    .stall_count    (stall_count),
    .flush_count    (flush_count)
  );

  int n_assert = 0;
  int n_fail   = 0;

  // Reference model: "mode" is 0 = just reset (boot cycle pending), 1 = running, 2 = faulted.
  int          m_mode;
  logic [31:0] m_pc, m_instr, m_ifpc, m_ifpc4, m_fpc, m_fetch, m_stall, m_flush;
  logic        m_ifv, m_fault;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_assert++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  task automatic model_step(input logic rst, input logic st, input logic rv,
                            input logic [31:0] rpc, input logic err);
    if (rst) begin
      m_mode = 0; m_pc = 32'h0; m_ifv = 0; m_instr = 0; m_ifpc = 0; m_ifpc4 = 0;
      m_fault = 0; m_fpc = 0; m_fetch = 0; m_stall = 0; m_flush = 0;
    end else if (m_mode == 2) begin
      m_ifv = 0;
    end else if (m_mode == 0) begin
      m_mode = 1; m_ifv = 0;
    end else if (rv) begin
      m_pc = rpc; m_ifv = 0; m_flush = m_flush + 1;
    end else if (st) begin
      m_stall = m_stall + 1;
    end else if ((m_pc % 4) != 0 || m_pc >= MEM_WORDS * 4 || err) begin
      m_mode = 2; m_fault = 1; m_fpc = m_pc; m_ifv = 0;
    end else begin
      m_instr = mem[m_pc / 4]; m_ifpc = m_pc; m_ifpc4 = m_pc + 4;
      m_ifv = 1; m_pc = m_pc + 4; m_fetch = m_fetch + 1;
    end
  endtask

  task automatic check_all();
    chk("imem_addr",   32'(imem_addr),   (m_pc >> 2) % MEM_WORDS);
    chk("if_valid",    32'(if_valid),    32'(m_ifv));
    chk("if_instr",    if_instr,         m_instr);
    chk("if_pc",       if_pc,            m_ifpc);
    chk("if_pc_plus4", if_pc_plus4,      m_ifpc4);
    chk("fault",       32'(fault),       32'(m_fault));
    chk("fault_pc",    fault_pc,         m_fpc);
    chk("fetch_count", fetch_count,      m_fetch);
    chk("stall_count", stall_count,      m_stall);
    chk("flush_count", flush_count,      m_flush);
  endtask

  // Inputs are applied 1 time unit after an edge and hold until the next one.
  task automatic cycle(input logic rst, input logic st, input logic rv,
                       input logic [31:0] rpc, input logic err);
    reset = rst; stall = st; redirect_valid = rv; redirect_pc = rpc; imem_error = err;
    model_step(rst, st, rv, rpc, err);
    @(posedge clk);
    #1;
    check_all();
  endtask

  initial begin
    for (int i = 0; i < MEM_WORDS; i++) mem[i] = $urandom;
    mem[0] = 32'h2008_0005; mem[1] = 32'h2009_0003;
    mem[2] = 32'h0109_5020; mem[3] = 32'hAC0A_0000;

    // Reset, boot, two fetches, a 3-cycle stall holding if_pc=4, then two more fetches.
    #1;
    cycle(1, 0, 0, 0, 0);
    chk("rst_if_valid", 32'(if_valid), 32'd0);
    chk("rst_counters", fetch_count | stall_count | flush_count, 32'd0);
    cycle(0, 0, 0, 0, 0);
    chk("boot_if_valid", 32'(if_valid), 32'd0);
    cycle(0, 0, 0, 0, 0);
    chk("fetch0_pc", if_pc, 32'h0);
    chk("fetch0_instr", if_instr, 32'h2008_0005);
    cycle(0, 0, 0, 0, 0);
    chk("fetch1_pc", if_pc, 32'h4);
    for (int i = 0; i < 3; i++) begin
      cycle(0, 1, 0, 0, 0);
      chk("stall_pc", if_pc, 32'h4);
      chk("stall_instr", if_instr, 32'h2009_0003);
      chk("stall_addr", 32'(imem_addr), 32'd2);
    end
    chk("stall_count3", stall_count, 32'd3);
    cycle(0, 0, 0, 0, 0);
    chk("resume_pc", if_pc, 32'h8);
    chk("resume_instr", if_instr, 32'h0109_5020);
    cycle(0, 0, 0, 0, 0);
    chk("fetch3_pc", if_pc, 32'hC);
    chk("fetch3_instr", if_instr, 32'hAC0A_0000);
    chk("fetch_count4", fetch_count, 32'd4);

    // Redirect together with stall: the redirect wins, stall not counted.
    cycle(0, 1, 1, 32'h20, 0);
    chk("redir_bubble", 32'(if_valid), 32'd0);
    chk("redir_addr", 32'(imem_addr), 32'd8);
    chk("redir_flush", flush_count, 32'd1);
    chk("redir_stall", stall_count, 32'd3);
    cycle(0, 0, 0, 0, 0);
    chk("redir_pc", if_pc, 32'h20);

    // Misaligned redirect target faults one cycle later; FAULT ignores stall/redirect.
    cycle(0, 0, 1, 32'h22, 0);
    cycle(0, 0, 0, 0, 0);
    chk("mis_fault", 32'(fault), 32'd1);
    chk("mis_fault_pc", fault_pc, 32'h22);
    cycle(0, 1, 0, 0, 0);
    cycle(0, 0, 1, 32'h40, 0);
    cycle(0, 0, 0, 0, 0);
    chk("fault_sticky", 32'(fault), 32'd1);
    chk("fault_flush", flush_count, 32'd2);
    cycle(1, 0, 0, 0, 0);
    chk("fault_cleared", 32'(fault), 32'd0);
    chk("fault_rst_addr", 32'(imem_addr), 32'd0);

    // Sequential fetch off the end of memory faults rather than wrapping.
    cycle(0, 0, 0, 0, 0);
    cycle(0, 0, 1, 32'hF8, 0);
    cycle(0, 0, 0, 0, 0);
    chk("end_pc_f8", if_pc, 32'hF8);
    cycle(0, 0, 0, 0, 0);
    chk("end_pc_fc", if_pc, 32'hFC);
    chk("end_pc4_fc", if_pc_plus4, 32'h100);
    cycle(0, 0, 0, 0, 0);
    chk("end_fault", 32'(fault), 32'd1);
    chk("end_fault_pc", fault_pc, 32'h100);

    // Memory error fault, then reset mid-FAULT clears everything on that edge.
    cycle(1, 0, 0, 0, 0);
    cycle(0, 0, 0, 0, 0);
    cycle(0, 0, 1, 32'h10, 0);
    cycle(0, 0, 0, 0, 1);
    chk("err_fault_pc", fault_pc, 32'h10);
    cycle(0, 0, 0, 0, 0);
    cycle(1, 0, 0, 0, 0);
    chk("rst_in_fault", 32'(fault) | fault_pc | flush_count | if_pc, 32'd0);

    // Randomized traffic against the model.
    for (int i = 0; i < 400; i++) begin
      logic        r_rst, r_st, r_rv, r_err;
      logic [31:0] r_pc;
      r_rst = ($urandom_range(0, 99) < 2);
      r_st  = ($urandom_range(0, 99) < 25);
      r_rv  = ($urandom_range(0, 99) < 15);
      r_err = ($urandom_range(0, 99) < 3);
      case ($urandom_range(0, 9))
        0:       r_pc = 32'($urandom_range(0, 255)) | 32'd1;
        1:       r_pc = 32'h100 + 32'($urandom_range(0, 15)) * 4;
        default: r_pc = 32'($urandom_range(0, MEM_WORDS - 1)) * 4;
      endcase
      cycle(r_rst, r_st, r_rv, r_pc, r_err);
    end

    $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
    $finish;
  end

endmodule
